// File: rtl/ctrl_pipe.sv
// Carries decoded control through ID/EX, EX/MEM, MEM/WB with load-use stall and branch flush.
// ex_* +1, mem_* +2, wb_* +3 cycles after capture; stall is the only combinational output.
module ctrl_pipe #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               id_valid,
  input  logic               id_RegWrite,
  input  logic               id_RegDst,
  input  logic               id_ALUSrc,
  input  logic               id_Branch,
  input  logic               id_MemWrite,
  input  logic               id_MemRead,
  input  logic               id_MemToReg,
  input  logic               id_zeroExt,
  input  logic [ALUOP_W-1:0] id_ALUOp,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               br_taken,
  output logic               stall,
  output logic               ex_RegDst,
  output logic               ex_ALUSrc,
  output logic               ex_zeroExt,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic [REG_AW-1:0]  ex_dst,
  output logic               mem_Branch,
  output logic               mem_MemWrite,
  output logic               mem_MemRead,
  output logic               wb_RegWrite,
  output logic               wb_MemToReg,
  output logic [REG_AW-1:0]  wb_dst,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_to_reg;
    logic               branch;
    logic               mem_write;
    logic               mem_read;
    logic               reg_dst;
    logic               alu_src;
    logic               zero_ext;
    logic [ALUOP_W-1:0] alu_op;
    logic [REG_AW-1:0]  dst;
  } idex_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              branch;
    logic              mem_write;
    logic              mem_read;
    logic [REG_AW-1:0] dst;
  } exmem_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] dst;
  } memwb_t;

  idex_t            idex_q, idex_d;
  exmem_t           exmem_q, exmem_d;
  memwb_t           memwb_q, memwb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [REG_AW-1:0] id_dst;
  logic              uses_rt;
  logic              hz;
  logic [1:0]        cnt_inc;
  logic [CNT_W:0]    cnt_sum;

  always_comb begin
    id_dst  = id_RegDst ? id_rd : id_rt;
    uses_rt = ~id_ALUSrc | id_MemWrite | id_Branch;
    hz = idex_q.valid & idex_q.mem_read & idex_q.reg_write & id_valid &
         (idex_q.dst != '0) &
         ((idex_q.dst == id_rs) | ((idex_q.dst == id_rt) & uses_rt));
    stall = hz & ~br_taken;

    // Flushes, stalls and empty ID slots all enter EX as an all-zero word.
    idex_d = '0;
    if (id_valid && !hz && !br_taken) begin
      idex_d.valid      = 1'b1;
      idex_d.reg_write  = id_RegWrite & (id_dst != '0);
      idex_d.mem_to_reg = id_MemToReg;
      idex_d.branch     = id_Branch;
      idex_d.mem_write  = id_MemWrite;
      idex_d.mem_read   = id_MemRead;
      idex_d.reg_dst    = id_RegDst;
      idex_d.alu_src    = id_ALUSrc;
      idex_d.zero_ext   = id_zeroExt;
      idex_d.alu_op     = id_ALUOp;
      idex_d.dst        = id_dst;
    end

    exmem_d = '0;
    if (!br_taken) begin
      exmem_d.reg_write  = idex_q.reg_write;
      exmem_d.mem_to_reg = idex_q.mem_to_reg;
      exmem_d.branch     = idex_q.branch;
      exmem_d.mem_write  = idex_q.mem_write;
      exmem_d.mem_read   = idex_q.mem_read;
      exmem_d.dst        = idex_q.dst;
    end

    // The resolving branch sits in EX/MEM and always moves on to WB.
    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.dst        = exmem_q.dst;

    cnt_inc = br_taken ? 2'd2 : (hz ? 2'd1 : 2'd0);
    cnt_sum = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, cnt_inc};
    cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      cnt_q   <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_RegDst    = idex_q.reg_dst;
  assign ex_ALUSrc    = idex_q.alu_src;
  assign ex_zeroExt   = idex_q.zero_ext;
  assign ex_ALUOp     = idex_q.alu_op;
  assign ex_dst       = idex_q.dst;
  assign mem_Branch   = exmem_q.branch;
  assign mem_MemWrite = exmem_q.mem_write;
  assign mem_MemRead  = exmem_q.mem_read;
  assign wb_RegWrite  = memwb_q.reg_write;
  assign wb_MemToReg  = memwb_q.mem_to_reg;
  assign wb_dst       = memwb_q.dst;
  assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized bench for ctrl_pipe against a queue-based model of the three in-flight words,
// plus directed latency, load-use, flush, reset and saturation cases with literal expectations.
module tb_ctrl_pipe;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       id_valid, id_RegWrite, id_RegDst, id_ALUSrc, id_Branch;
  logic       id_MemWrite, id_MemRead, id_MemToReg, id_zeroExt;
  logic [4:0] id_ALUOp, id_rs, id_rt, id_rd;
  logic       br_taken;
  logic       stall, ex_RegDst, ex_ALUSrc, ex_zeroExt;
  logic [4:0] ex_ALUOp, ex_dst, wb_dst;
  logic       mem_Branch, mem_MemWrite, mem_MemRead, wb_RegWrite, wb_MemToReg;
  logic [15:0] bubble_cnt;

  always #5 Clk = ~Clk;

  ctrl_pipe dut (
    .Clk(Clk), .Rst_n(Rst_n), .id_valid(id_valid), .id_RegWrite(id_RegWrite),
    .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_Branch(id_Branch),
    .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead), .id_MemToReg(id_MemToReg),
    .id_zeroExt(id_zeroExt), .id_ALUOp(id_ALUOp), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .br_taken(br_taken), .stall(stall), .ex_RegDst(ex_RegDst),
    .ex_ALUSrc(ex_ALUSrc), .ex_zeroExt(ex_zeroExt), .ex_ALUOp(ex_ALUOp),
    .ex_dst(ex_dst), .mem_Branch(mem_Branch), .mem_MemWrite(mem_MemWrite),
    .mem_MemRead(mem_MemRead), .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg),
    .wb_dst(wb_dst), .bubble_cnt(bubble_cnt)
  );

  typedef struct packed {
    logic v, rw, m2r, br, mw, mr, rdst, asrc, zext;
    logic [4:0] op;
    logic [4:0] dst;
  } cw_t;

  cw_t pipe[$];          // [0] in EX, [1] in MEM, [2] in WB
  int  cnt_m;
  int  total = 0;
  int  bad = 0;
  bit  chk_en = 0;
  bit  last_stall = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cw_t id_word();
    cw_t w = '0;
    if (id_valid) begin
      w.v = 1'b1;
      w.dst = id_RegDst ? id_rd : id_rt;
      w.rw = id_RegWrite && (w.dst != 5'd0);
      w.m2r = id_MemToReg; w.br = id_Branch; w.mw = id_MemWrite; w.mr = id_MemRead;
      w.rdst = id_RegDst; w.asrc = id_ALUSrc; w.zext = id_zeroExt; w.op = id_ALUOp;
    end
    return w;
  endfunction

  function automatic bit m_stall();
    cw_t e = pipe[0];
    bit uses_rt = !id_ALUSrc || id_MemWrite || id_Branch;
    bit hz = e.v && e.mr && e.rw && id_valid && (e.dst != 5'd0) &&
             ((e.dst == id_rs) || ((e.dst == id_rt) && uses_rt));
    return hz && !br_taken;
  endfunction

  function automatic logic [39:0] exp_vec();
    logic [15:0] c = cnt_m[15:0];
    return {m_stall(), pipe[0].rdst, pipe[0].asrc, pipe[0].zext, pipe[0].op, pipe[0].dst,
            pipe[1].br, pipe[1].mw, pipe[1].mr, pipe[2].rw, pipe[2].m2r, pipe[2].dst, c};
  endfunction

  function automatic logic [39:0] dut_vec();
    return {stall, ex_RegDst, ex_ALUSrc, ex_zeroExt, ex_ALUOp, ex_dst,
            mem_Branch, mem_MemWrite, mem_MemRead, wb_RegWrite, wb_MemToReg, wb_dst, bubble_cnt};
  endfunction

  task automatic model_reset();
    pipe.delete();
    repeat (3) pipe.push_back('0);
    cnt_m = 0;
    last_stall = 0;
  endtask

  task automatic model_edge();
    bit st = m_stall();
    cw_t nw = (br_taken || st) ? cw_t'('0) : id_word();
    if (br_taken) begin
      pipe[0] = '0;
      cnt_m += 2;
    end else if (st) begin
      cnt_m += 1;
    end
    if (cnt_m > 65535) cnt_m = 65535;
    pipe.push_front(nw);
    void'(pipe.pop_back());
    last_stall = st;
  endtask

  task automatic step();
    @(posedge Clk);
    if (Rst_n) model_edge();
    #1;
  endtask

  task automatic set_id(input logic v, rw, rdst, asrc, br, mw, mr, m2r,
                        input logic [4:0] op, rs, rt, rd);
    id_valid = v; id_RegWrite = rw; id_RegDst = rdst; id_ALUSrc = asrc; id_Branch = br;
    id_MemWrite = mw; id_MemRead = mr; id_MemToReg = m2r; id_zeroExt = 1'b0;
    id_ALUOp = op; id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
  endtask

  function automatic logic [4:0] rreg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic rand_id();
    if ($urandom_range(0, 7) == 0) idle();
    else begin
      set_id(1, 1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), 1'($urandom),
             5'($urandom), rreg(), rreg(), rreg());
      id_zeroExt = 1'($urandom);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) check("cycle", dut_vec(), exp_vec());
  end

  initial begin
    idle();
    br_taken = 1'b0;
    model_reset();
    step(); step();
    check("reset_state", dut_vec(), 40'h0);
    Rst_n = 1'b1;
    chk_en = 1'b1;

    // Latency of an R-format word, then the same word writing r0.
    set_id(1, 1, 1, 0, 0, 0, 0, 1, 5'd0, 5'd1, 5'd2, 5'd9);
    step(); idle();
    check("lat_ex_dst", 40'(ex_dst), 40'd9);
    check("lat_ex_regdst", 40'(ex_RegDst), 40'd1);
    step(); step();
    check("lat_wb_rw", 40'(wb_RegWrite), 40'd1);
    check("lat_wb_dst", 40'(wb_dst), 40'd9);
    check("lat_wb_m2r", 40'(wb_MemToReg), 40'd1);
    set_id(1, 1, 1, 0, 0, 0, 0, 1, 5'd0, 5'd1, 5'd2, 5'd0);
    step(); idle(); step(); step();
    check("r0_wb_rw", 40'(wb_RegWrite), 40'd0);

    // Load-use on rs stalls once; addi reading only rt does not.
    set_id(1, 1, 0, 1, 0, 0, 1, 1, 5'd0, 5'd1, 5'd8, 5'd0);
    step();
    set_id(1, 1, 1, 0, 0, 0, 0, 0, 5'd2, 5'd8, 5'd2, 5'd3);
    #1 check("lu_stall", 40'(stall), 40'd1);
    step();
    check("lu_ex_bubble", {ex_RegDst, ex_ALUSrc, ex_zeroExt, ex_ALUOp, ex_dst}, 40'd0);
    check("lu_stall_clear", 40'(stall), 40'd0);
    check("lu_cnt", 40'(bubble_cnt), 40'd1);
    check("lu_mem_load", 40'(mem_MemRead), 40'd1);
    step(); idle();
    check("lu_consumer_ex", 40'(ex_dst), 40'd3);
    set_id(1, 1, 0, 1, 0, 0, 1, 1, 5'd0, 5'd1, 5'd8, 5'd0);
    step();
    set_id(1, 1, 0, 1, 0, 0, 0, 0, 5'd1, 5'd1, 5'd8, 5'd0);
    #1 check("addi_no_stall", 40'(stall), 40'd0);
    step(); idle();
    check("addi_ex_dst", 40'(ex_dst), 40'd8);
    check("addi_cnt", 40'(bubble_cnt), 40'd1);

    // Branch in MEM, load in EX, dependent op in ID, then flush.
    set_id(1, 0, 0, 0, 1, 0, 0, 0, 5'd6, 5'd4, 5'd5, 5'd0);
    step();
    set_id(1, 1, 0, 1, 0, 0, 1, 1, 5'd0, 5'd1, 5'd8, 5'd0);
    step();
    set_id(1, 1, 1, 0, 0, 0, 0, 0, 5'd2, 5'd8, 5'd2, 5'd3);
    #1 check("fl_hazard_seen", 40'(stall), 40'd1);
    br_taken = 1'b1;
    #1 check("fl_stall_masked", 40'(stall), 40'd0);
    check("fl_mem_branch", 40'(mem_Branch), 40'd1);
    step();
    br_taken = 1'b0; idle();
    check("fl_ex_zero", {ex_RegDst, ex_ALUSrc, ex_zeroExt, ex_ALUOp, ex_dst}, 40'd0);
    check("fl_mem_zero", {mem_Branch, mem_MemWrite, mem_MemRead}, 40'd0);
    check("fl_wb_rw", 40'(wb_RegWrite), 40'd0);
    check("fl_wb_dst", 40'(wb_dst), 40'd5);
    check("fl_cnt", 40'(bubble_cnt), 40'd3);

    // Random traffic; a stalled instruction is held in ID.
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) rand_id();
      br_taken = ($urandom_range(0, 7) == 0);
      step();
    end

    // Fill all stages, then reset asynchronously between edges.
    br_taken = 1'b0;
    set_id(1, 1, 1, 0, 0, 0, 0, 0, 5'd3, 5'd0, 5'd0, 5'd5);
    repeat (3) step();
    check("pre_rst_wb_dst", 40'(wb_dst), 40'd5);
    #2 Rst_n = 1'b0;
    model_reset();
    #1 check("midrst_zero", dut_vec(), 40'h0);
    idle();
    step(); step();
    Rst_n = 1'b1;
    step();
    check("post_rst_wb_rw", 40'(wb_RegWrite), 40'd0);

    // Saturation: fresh counter driven to FFFE with flushes.
    Rst_n = 1'b0;
    model_reset();
    step();
    Rst_n = 1'b1;
    br_taken = 1'b1;
    repeat (32767) step();
    check("sat_fffe", 40'(bubble_cnt), 40'h0fffe);
    step();
    check("sat_ffff", 40'(bubble_cnt), 40'h0ffff);
    repeat (3) step();
    br_taken = 1'b0;
    set_id(1, 1, 0, 1, 0, 0, 1, 1, 5'd0, 5'd1, 5'd8, 5'd0);
    step();
    set_id(1, 1, 1, 0, 0, 0, 0, 0, 5'd2, 5'd8, 5'd2, 5'd3);
    step(); idle(); step();
    check("sat_hold", 40'(bubble_cnt), 40'h0ffff);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
